router_pkt_gen: RTL

ROUTER_PKT_GEN -- requirements
Module: router_pkt_gen

---
 rtl/router_pkt_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/router_pkt_gen.sv
// rtl/router_pkt_gen.sv - packet generator: header, arithmetic payload, parity byte, with backpressure
module router_pkt_gen (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  input  logic [7:0] base,
  input  logic [7:0] step,
  input  logic       inj_err,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_in,
  output logic       gen_active,
  output logic       done,
  output logic       cmd_err,
  output logic [7:0] pkt_count
);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, DONE} state_t;

  state_t     state, state_n;
  logic [5:0] len_q, len_n;
  logic [7:0] base_q, base_n;
  logic [7:0] step_q, step_n;
  logic       inj_q, inj_n;
  logic [5:0] idx, idx_n;
  logic [7:0] par, par_n;
  logic       pkt_valid_n, gen_active_n, done_n, cmd_err_n;
  logic [7:0] data_in_n, pkt_count_n;

  // Outputs are computed for the next state and registered with it.
  always_comb begin
    state_n      = state;
    len_n        = len_q;
    base_n       = base_q;
    step_n       = step_q;
    inj_n        = inj_q;
    idx_n        = idx;
    par_n        = par;
    pkt_valid_n  = pkt_valid;
    data_in_n    = data_in;
    gen_active_n = gen_active;
    done_n       = 1'b0;
    cmd_err_n    = 1'b0;
    pkt_count_n  = pkt_count;
    case (state)
      IDLE: begin
        pkt_valid_n  = 1'b0;
        data_in_n    = 8'h00;
        gen_active_n = 1'b0;
        if (start) begin
          if (dest != 2'd3 && len != 6'd0) begin
            state_n      = HEADER;
            len_n        = len;
            base_n       = base;
            step_n       = step;
            inj_n        = inj_err;
            idx_n        = 6'd0;
            par_n        = 8'h00;
            pkt_valid_n  = 1'b1;
            data_in_n    = {len, dest};
            gen_active_n = 1'b1;
          end else begin
            cmd_err_n = 1'b1;
          end
        end
      end
      HEADER: begin
        if (!busy) begin
          state_n   = PAYLOAD;
          par_n     = par ^ data_in;
          idx_n     = 6'd0;
          data_in_n = base_q;
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          par_n = par ^ data_in;
          if (idx == len_q - 6'd1) begin
            state_n     = PARITY;
            pkt_valid_n = 1'b0;
            data_in_n   = (par ^ data_in) ^ {8{inj_q}};
          end else begin
            idx_n     = idx + 6'd1;
            data_in_n = data_in + step_q;
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          state_n      = DONE;
          pkt_valid_n  = 1'b0;
          data_in_n    = 8'h00;
          gen_active_n = 1'b0;
          done_n       = 1'b1;
          pkt_count_n  = pkt_count + 8'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n      = IDLE;
        pkt_valid_n  = 1'b0;
        data_in_n    = 8'h00;
        gen_active_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      len_q      <= 6'd0;
      base_q     <= 8'h00;
      step_q     <= 8'h00;
      inj_q      <= 1'b0;
      idx        <= 6'd0;
      par        <= 8'h00;
      pkt_valid  <= 1'b0;
      data_in    <= 8'h00;
      gen_active <= 1'b0;
      done       <= 1'b0;
      cmd_err    <= 1'b0;
      pkt_count  <= 8'h00;
    end else begin
      state      <= state_n;
      len_q      <= len_n;
      base_q     <= base_n;
      step_q     <= step_n;
      inj_q      <= inj_n;
      idx        <= idx_n;
      par        <= par_n;
      pkt_valid  <= pkt_valid_n;
      data_in    <= data_in_n;
      gen_active <= gen_active_n;
      done       <= done_n;
      cmd_err    <= cmd_err_n;
      pkt_count  <= pkt_count_n;
    end
  end

endmodule
